// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants and capture FSM state type for PWM readback.
// Revision    : 1.0  initial release
// ============================================================================
package pwm_pkg;

    localparam int RESOLUTION_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sync_edge
// Description : Two-flop synchroniser for an asynchronous input plus edge detect.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic s2_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s2_prev_q <= 1'b0;
        end else begin
            s1_q      <= async_in;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
        end
    end

    assign sync_out = s2_q;
    assign rise     = s2_q & ~s2_prev_q;
    assign fall     = ~s2_q & s2_prev_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures high time and period of an asynchronous PWM input in
//               prescaler ticks and reports duty/period with a valid strobe.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int RESOLUTION    = RESOLUTION_DEF,
    parameter int DVSR          = 4882,
    parameter int TIMEOUT_TICKS = 512,
    localparam int PW           = $clog2(TIMEOUT_TICKS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwm_in,
    output logic [RESOLUTION-1:0] duty,
    output logic [PW-1:0]         period,
    output logic                  valid,
    output logic                  stuck
);

    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int HW = RESOLUTION + 1;

    localparam logic [CW-1:0]         CNT_LAST    = CW'(DVSR - 1);
    localparam logic [CW-1:0]         CNT_ONE     = CW'(1);
    localparam logic [PW-1:0]         PER_ONE     = PW'(1);
    localparam logic [PW-1:0]         PER_MAX     = {PW{1'b1}};
    localparam logic [PW-1:0]         PER_TIMEOUT = PW'(TIMEOUT_TICKS);
    localparam logic [HW-1:0]         HIGH_ONE    = HW'(1);
    localparam logic [HW-1:0]         HIGH_MAX    = {HW{1'b1}};
    localparam logic [RESOLUTION-1:0] DUTY_MAX    = {RESOLUTION{1'b1}};

    logic s2;
    logic rise;
    logic fall_unused;

    pwm_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pwm_in),
        .sync_out (s2),
        .rise     (rise),
        .fall     (fall_unused)
    );

    cap_state_t            state_q,    state_d;
    logic [CW-1:0]         cnt_q,      cnt_d;
    logic [PW-1:0]         per_acc_q,  per_acc_d;
    logic [HW-1:0]         high_acc_q, high_acc_d;
    logic [RESOLUTION-1:0] duty_q,     duty_d;
    logic [PW-1:0]         period_q,   period_d;
    logic                  valid_q,    valid_d;
    logic                  stuck_q,    stuck_d;

    logic                  tick;
    logic                  timeout;
    logic [RESOLUTION-1:0] duty_sat;

    assign tick     = (cnt_q == CNT_LAST);
    assign timeout  = (per_acc_q == PER_TIMEOUT);
    assign duty_sat = high_acc_q[RESOLUTION] ? DUTY_MAX : high_acc_q[RESOLUTION-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            per_acc_q  <= '0;
            high_acc_q <= '0;
            duty_q     <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            per_acc_q  <= per_acc_d;
            high_acc_q <= high_acc_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_ONE;
        per_acc_d  = per_acc_q;
        high_acc_d = high_acc_q;
        duty_d     = duty_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;

        if (tick) begin
            cnt_d = '0;
            if (per_acc_q != PER_MAX) begin
                per_acc_d = per_acc_q + PER_ONE;
            end
            if (s2 && (high_acc_q != HIGH_MAX)) begin
                high_acc_d = high_acc_q + HIGH_ONE;
            end
        end

        // The rise cycle is itself the first clock of the new period, so the
        // prescaler restarts at 1; a period of N*DVSR clocks then reads N ticks.
        if (rise) begin
            cnt_d      = CNT_ONE;
            per_acc_d  = '0;
            high_acc_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end else if (timeout) begin
                    state_d = STUCK;
                    stuck_d = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    duty_d   = duty_sat;
                    period_d = per_acc_q;
                    valid_d  = 1'b1;
                end else if (timeout) begin
                    state_d  = STUCK;
                    stuck_d  = 1'b1;
                    duty_d   = s2 ? DUTY_MAX : '0;
                    period_d = '0;
                    valid_d  = 1'b1;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d = MEASURE;
                    stuck_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign duty   = duty_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign stuck  = stuck_q;

endmodule
`default_nettype wire
